// File: rtl/rrf_multi_commit_pkg.sv
// Shared types and default sizes for the retirement register file.
package rrf_multi_commit_pkg;
  localparam int PR_WIDTH         = 6;
  localparam int RRF_NUM          = 32;
  localparam int RRF_AR_WIDTH     = $clog2(RRF_NUM);
  localparam int RRF_COMMIT_WIDTH = 2;
  localparam int RRF_FREE_PORTS   = 1;
  localparam int RRF_FREE_Q_DEPTH = 8;

  typedef struct packed {
    logic                    valid;
    logic [RRF_AR_WIDTH-1:0] arch;
    logic [PR_WIDTH-1:0]     preg;
  } rrf_commit_t;
endpackage

// File: rtl/rrf_free_queue.sv
// Circular FIFO of freed phys regs: up to PUSH_W pushes and POP_W pops per cycle.
// Outputs are derived only from registered head/count/storage.
module rrf_free_queue #(
  parameter int PUSH_W = 2,
  parameter int POP_W  = 1,
  parameter int DEPTH  = 8,
  parameter int DAT_W  = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT_W-1:0]               push_cnt,
  input  logic [PUSH_W-1:0][DAT_W-1:0]   push_dat,
  input  logic                           pop_ready,
  output logic [POP_W-1:0]               pop_valid,
  output logic [POP_W-1:0][DAT_W-1:0]    pop_dat,
  output logic [CNT_W-1:0]               count
);
  logic [DAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    if (pop_ready)
      pop_cnt = (count > CNT_W'(POP_W)) ? CNT_W'(POP_W) : count;
    for (int k = 0; k < POP_W; k++) begin
      pop_valid[k] = count > CNT_W'(k);
      pop_dat[k]   = mem[head + PTR_W'(k)];
    end
  end

  // Storage is not reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < PUSH_W; i++)
        if (CNT_W'(i) < push_cnt) mem[tail + PTR_W'(i)] <= push_dat[i];
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + push_cnt - pop_cnt;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (32'(count) + 32'(push_cnt)) <= 32'(DEPTH));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    32'(count) <= 32'(DEPTH));
endmodule

// File: rtl/rrf_multi_commit.sv
// Retirement register file: committed arch->phys map, intra-bundle old-reg resolution,
// freed-reg queue draining to the free list; commit stalls when the queue lacks room.
module rrf_multi_commit #(
  parameter int COMMIT_WIDTH = rrf_multi_commit_pkg::RRF_COMMIT_WIDTH,
  parameter int ARCH_REGS    = rrf_multi_commit_pkg::RRF_NUM,
  parameter int PR_WIDTH     = rrf_multi_commit_pkg::PR_WIDTH,
  parameter int FREE_PORTS   = rrf_multi_commit_pkg::RRF_FREE_PORTS,
  parameter int FREE_Q_DEPTH = rrf_multi_commit_pkg::RRF_FREE_Q_DEPTH,
  localparam int AR_WIDTH    = $clog2(ARCH_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [COMMIT_WIDTH-1:0]               commit_valid,
  input  logic [COMMIT_WIDTH-1:0][AR_WIDTH-1:0] commit_arch,
  input  logic [COMMIT_WIDTH-1:0][PR_WIDTH-1:0] commit_preg,
  output logic                                  commit_ready,
  output logic [FREE_PORTS-1:0]                 free_valid,
  output logic [FREE_PORTS-1:0][PR_WIDTH-1:0]   free_preg,
  input  logic                                  free_ready,
  output logic [63:0]                           commit_order,
  output logic [ARCH_REGS-1:0][PR_WIDTH-1:0]    arch_phys_map_copy
);
  import rrf_multi_commit_pkg::*;

  localparam int CNT_W = $clog2(FREE_Q_DEPTH + 1);

  rrf_commit_t                              lane [COMMIT_WIDTH];
  logic [PR_WIDTH-1:0]                      old_preg [COMMIT_WIDTH];
  logic [ARCH_REGS-1:0][PR_WIDTH-1:0]       map_q, map_d;
  logic [COMMIT_WIDTH-1:0][PR_WIDTH-1:0]    push_dat;
  logic [CNT_W-1:0]                         push_cnt, q_count;
  logic [63:0]                              order_inc;
  logic                                     fire;

  // Credit check uses the registered count only, so a same-cycle pop never opens the gate.
  assign commit_ready       = q_count <= CNT_W'(FREE_Q_DEPTH - COMMIT_WIDTH);
  assign fire               = commit_ready;
  assign arch_phys_map_copy = map_q;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++)
      lane[i] = '{valid: commit_valid[i], arch: commit_arch[i], preg: commit_preg[i]};
  end

  // Old reg: youngest older writer of the same arch in this bundle, else the committed map.
  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      old_preg[i] = map_q[lane[i].arch];
      for (int j = 0; j < i; j++)
        if (lane[j].valid && lane[j].arch != '0 && lane[j].arch == lane[i].arch)
          old_preg[i] = lane[j].preg;
    end
  end

  always_comb begin
    map_d     = map_q;
    order_inc = '0;
    push_cnt  = '0;
    push_dat  = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (lane[i].valid) order_inc = order_inc + 64'd1;
      if (lane[i].valid && lane[i].arch != '0) map_d[lane[i].arch] = lane[i].preg;
    end
    // Walk youngest to oldest, shifting up, so the oldest pusher lands in slot 0.
    for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
      if (lane[i].valid && lane[i].arch != '0 && old_preg[i] != '0) begin
        push_dat    = push_dat << PR_WIDTH;
        push_dat[0] = old_preg[i];
        push_cnt    = push_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= PR_WIDTH'(a);
      commit_order <= '0;
    end else if (fire) begin
      map_q        <= map_d;
      commit_order <= commit_order + order_inc;
    end
  end

  rrf_free_queue #(
    .PUSH_W (COMMIT_WIDTH),
    .POP_W  (FREE_PORTS),
    .DEPTH  (FREE_Q_DEPTH),
    .DAT_W  (PR_WIDTH)
  ) u_free_queue (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (fire ? push_cnt : '0),
    .push_dat  (push_dat),
    .pop_ready (free_ready),
    .pop_valid (free_valid),
    .pop_dat   (free_preg),
    .count     (q_count)
  );

  a_x0_zero: assert property (@(posedge clk) disable iff (rst) map_q[0] == '0);
endmodule
